// File: rtl/spi_pixel_master.sv
// rtl/spi_pixel_master.sv - SPI mode-0 master that streams 16-bit pixel words, one frame per request
module spi_pixel_master #(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_PIXELS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_ss,
  input  logic        spi_miso
);

  localparam int               CNT_W     = $clog2(FRAME_PIXELS) + 1;
  localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(FRAME_PIXELS);

  typedef enum logic [2:0] {
    IDLE,
    SS_SETUP,
    WAIT_DATA,
    SHIFT,
    SS_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       div_cnt, div_cnt_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [15:0]      shreg, shreg_nxt;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
  logic             spi_clk_nxt, spi_mosi_nxt, spi_ss_nxt;
  logic             busy_nxt, frame_done_nxt;
  logic             div_wrap;
  logic             unused_miso;

  assign unused_miso = spi_miso;
  assign div_wrap    = (div_cnt == DIV_LAST);
  assign pix_ready   = (state == WAIT_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    pix_cnt_nxt    = pix_cnt;
    spi_clk_nxt    = spi_clk;
    spi_mosi_nxt   = spi_mosi;
    spi_ss_nxt     = spi_ss;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        spi_ss_nxt  = 1'b1;
        spi_clk_nxt = 1'b0;
        busy_nxt    = 1'b0;
        if (frame_start) begin
          state_nxt   = SS_SETUP;
          spi_ss_nxt  = 1'b0;
          busy_nxt    = 1'b1;
          div_cnt_nxt = '0;
          pix_cnt_nxt = '0;
        end
      end

      SS_SETUP: begin
        if (div_wrap) begin
          state_nxt   = WAIT_DATA;
          div_cnt_nxt = '0;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      WAIT_DATA: begin
        if (pix_valid) begin
          state_nxt    = SHIFT;
          shreg_nxt    = pix_data;
          spi_mosi_nxt = pix_data[15];
          pix_cnt_nxt  = pix_cnt + CNT_W'(1);
          bit_cnt_nxt  = '0;
          div_cnt_nxt  = '0;
        end
      end

      SHIFT: begin
        if (div_wrap) begin
          div_cnt_nxt = '0;
          spi_clk_nxt = ~spi_clk;
          // Falling edge: either advance to the next bit or finish the word.
          if (spi_clk) begin
            if (bit_cnt == 4'd15) begin
              state_nxt = (pix_cnt < PIX_TOTAL) ? WAIT_DATA : SS_HOLD;
            end else begin
              bit_cnt_nxt  = bit_cnt + 4'd1;
              shreg_nxt    = {shreg[14:0], shreg[15]};
              spi_mosi_nxt = shreg[14];
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      SS_HOLD: begin
        if (div_wrap) begin
          state_nxt      = IDLE;
          div_cnt_nxt    = '0;
          spi_ss_nxt     = 1'b1;
          busy_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pix_cnt    <= '0;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_ss     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      pix_cnt    <= pix_cnt_nxt;
      spi_clk    <= spi_clk_nxt;
      spi_mosi   <= spi_mosi_nxt;
      spi_ss     <= spi_ss_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_pixel_master.sv
// tb/tb_spi_pixel_master.sv - randomized bench for spi_pixel_master with a cycle-level reference model
module tb_spi_pixel_master;

  localparam int D       = 2;
  localparam int N       = 4;
  localparam int SRC_MAX = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        pix_valid = 1'b0;
  logic        spi_miso = 1'b0;
  logic        pix_ready, busy, frame_done, spi_clk, spi_mosi, spi_ss;

  spi_pixel_master #(.CLK_DIV(D), .FRAME_PIXELS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_ss      (spi_ss),
    .spi_miso    (spi_miso)
  );

  always #5 clk = ~clk;

  // Reference model: frame phase plus cycles elapsed in that phase.
  typedef enum {M_IDLE, M_SETUP, M_WAIT, M_WORD, M_HOLD} mph_t;
  mph_t        m_ph = M_IDLE;
  int          m_k = 0;
  int          m_cnt = 0;
  int          take_total = 0;
  logic [15:0] m_word = 16'h0;
  logic        m_done = 1'b0;
  logic [15:0] exp_w [0:127];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph   <= M_IDLE;
      m_k    <= 0;
      m_cnt  <= 0;
      m_word <= 16'h0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_ph)
        M_IDLE: if (frame_start) begin m_ph <= M_SETUP; m_k <= 0; m_cnt <= 0; end
        M_SETUP: if (m_k == D - 1) begin m_ph <= M_WAIT; m_k <= 0; end else m_k <= m_k + 1;
        M_WAIT: if (pix_valid) begin
          m_word <= pix_data;
          exp_w[take_total] <= pix_data;
          take_total <= take_total + 1;
          m_cnt <= m_cnt + 1;
          m_ph <= M_WORD;
          m_k <= 0;
        end
        M_WORD: if (m_k == 32 * D - 1) begin
          m_ph <= (m_cnt < N) ? M_WAIT : M_HOLD;
          m_k <= 0;
        end else m_k <= m_k + 1;
        M_HOLD: if (m_k == D - 1) begin m_ph <= M_IDLE; m_done <= 1'b1; m_k <= 0; end
                else m_k <= m_k + 1;
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] src_w [0:SRC_MAX-1];
  int          src_gap [0:SRC_MAX-1];
  int          src_n = 0;
  int          src_skip = 0;
  int          gap_run = 0;
  int          last_idx = -1;
  logic        prev_clk = 1'b0;
  logic [15:0] sl_word = 16'h0;
  int          sl_bits = 0;
  int          cap_total = 0;
  logic [15:0] cap_log [0:127];
  int          rises = 0;
  int          done_cnt = 0;
  bit          saw_done = 1'b0;
  int          last_high_cyc = 0;
  logic [15:0] lit_a [4] = '{16'hF000, 16'h0F00, 16'h00F0, 16'h000F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    int       idx;
    logic     e_clk, e_mosi;
    logic [5:0] e_v, a_v;
    @(negedge clk);
    cyc++;
    e_clk  = (m_ph == M_WORD) && (((m_k / D) % 2) == 1);
    e_mosi = (m_ph == M_WORD) ? m_word[15 - m_k / (2 * D)] : m_word[0];
    e_v = {e_clk, e_mosi, m_ph == M_IDLE, m_ph != M_IDLE, m_done, m_ph == M_WAIT};
    a_v = {spi_clk, spi_mosi, spi_ss, busy, frame_done, pix_ready};
    check($sformatf("outputs{clk,mosi,ss,busy,done,ready}@%0d", cyc), 32'(a_v), 32'(e_v));

    // Slave receiver: shifts in MOSI on every observed spi_clk rise.
    if (reset) begin
      sl_bits   = 0;
      sl_word   = 16'h0;
      cap_total = take_total;
    end else if (spi_clk && !prev_clk) begin
      rises++;
      sl_word = {sl_word[14:0], spi_mosi};
      sl_bits++;
      if (sl_bits == 16) begin
        check($sformatf("slave word %0d", cap_total), 32'(sl_word), 32'(exp_w[cap_total]));
        cap_log[cap_total] = sl_word;
        cap_total++;
        sl_bits = 0;
      end
    end
    prev_clk = spi_clk;
    if (spi_clk) last_high_cyc = cyc;
    if (frame_done) begin
      saw_done = 1'b1;
      done_cnt++;
      check("done latency after last high sample", 32'(cyc - last_high_cyc), 32'(D + 1));
    end

    idx = take_total + src_skip;
    if (idx != last_idx) begin
      gap_run  = 0;
      last_idx = idx;
    end
    spi_miso = 1'($urandom);
    if (idx < src_n && gap_run >= src_gap[idx]) begin
      pix_valid = 1'b1;
      pix_data  = src_w[idx];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 16'($urandom);
      if (idx < src_n && m_ph == M_WAIT) gap_run++;
    end
  endtask

  task automatic run_until_done(input bit spam);
    int n;
    n = 0;
    saw_done = 1'b0;
    while (!saw_done && n < 3000) begin
      frame_start = spam && ($urandom_range(0, 9) == 0);
      tick();
      frame_start = 1'b0;
      n++;
    end
    check("frame_done seen before timeout", 32'(saw_done), 32'd1);
  endtask

  task automatic run_frame(input bit spam, output int first);
    int r0, d0;
    first = take_total;
    r0 = rises;
    d0 = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_until_done(spam);
    repeat (D + 3) tick();
    check("rising edges per frame", 32'(rises - r0), 32'(16 * N));
    check("frame_done pulses per frame", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int  first;
    int  r_abort;
    bit  found;
    for (int i = 0; i < SRC_MAX; i++) begin
      src_w[i]   = 16'($urandom);
      src_gap[i] = 0;
    end
    for (int i = 0; i < 4; i++) src_w[i] = lit_a[i];
    src_w[4]   = 16'hA5C3;
    src_gap[6] = 50;
    src_w[12]  = 16'h1234;
    for (int i = 16; i < 32; i++)
      src_gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
    src_n = 32;

    repeat (3) tick();
    check("reset state {ss,clk,mosi,ready,busy,done}",
          32'({spi_ss, spi_clk, spi_mosi, pix_ready, busy, frame_done}), 32'b100000);
    reset = 1'b0;
    repeat (4) tick();

    // Four literal words, frame_start spammed while busy.
    run_frame(1'b1, first);
    for (int i = 0; i < 4; i++)
      check($sformatf("frame A word %0d", i), 32'(cap_log[first + i]), 32'(lit_a[i]));

    // 0xA5C3 first, 50-cycle stall before the third word.
    repeat (3) tick();
    run_frame(1'b0, first);
    check("frame B word 0 is A5C3", 32'(cap_log[first]), 32'h0000A5C3);

    // Abort mid word 2 at bit 7.
    repeat (2) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      if (m_ph == M_WORD && m_cnt == 2 && m_k == 16 * D) found = 1'b1;
      else tick();
    end
    check("reached word 2 bit 7", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async reset {ss,clk,mosi,ready,busy,done}",
          32'({spi_ss, spi_clk, spi_mosi, pix_ready, busy, frame_done}), 32'b100000);
    r_abort = rises;
    repeat (3) tick();
    reset = 1'b0;
    src_skip = 12 - take_total;
    repeat (6) tick();
    check("no spi_clk edges after abort", 32'(rises - r_abort), 32'd0);

    run_frame(1'b1, first);
    check("first word after abort", 32'(cap_log[first]), 32'h00001234);

    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 6)) tick();
      run_frame(1'b1, first);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
